lock_ctrl: RTL and testbench
============================

# lock_ctrl

Attempt sequencer placed between the raw keypad buttons and the two-button `lock` FSM. It edge-detects presses and forwards each one as a single-cycle `b0`/`b1` pulse. It groups presses into fixed-length attempts and checks the lock's `unlock` result after each attempt. It counts failures, enforces a lockout after repeated failures, and clears the lock after a door-open window or an abandoned entry.

## Interface
- `CODE_LEN`, 4: presses per attempt (≥1).
- `MAX_FAIL`, 3: consecutive failed attempts that trigger lockout (≥1).
- `CHECK_WAIT`, 2: cycles from the last forwarded pulse to sampling `unlock_in`.
- `OPEN_CYC`, 16: cycles `door_open` stays high.
- `LOCKOUT_CYC`, 32: cycles of lockout.
- `IDLE_CYC`, 20: ENTRY inactivity timeout, in cycles.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `btn0`, `btn1` in 1: button levels, already synchronous to `clk`.
- `unlock_in` in 1: `unlock` output of the lock FSM.
- `b0`, `b1` out 1: one-cycle press pulses to the lock FSM.
- `lock_clr` out 1: one-cycle active-high clear pulse to the lock FSM.
- `door_open` out 1: high in OPEN.
- `locked_out` out 1: high in LOCKOUT.
- `fail_cnt` out $clog2(MAX_FAIL+1): consecutive failure count.
- `state` out 3: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, LOCKOUT=4.

## Operation
- **Edge detect:** a press is a rising edge, where the current level is 1 and the registered previous level is 0.
  - A rise on both buttons in the same cycle is discarded: no pulse, no count.
  - Previous-level registers update in every state, so a held button never re-fires.
- **Accepting presses:** presses are accepted only in IDLE and ENTRY. Each accepted press:
  - registers `b0` or `b1` high for exactly one cycle;
  - increments `press_cnt`;
  - reloads the inactivity timer to 0.
- **IDLE:** the first accepted press moves to ENTRY with `press_cnt`=1.
- **ENTRY:**
  - When `press_cnt` reaches `CODE_LEN`, go to CHECK with the wait counter at 0.
  - If the inactivity timer reaches `IDLE_CYC`-1: pulse `lock_clr`, clear `press_cnt`, go to IDLE. This is not counted as a failure.
- **CHECK:** presses are ignored. After `CHECK_WAIT` cycles, sample `unlock_in`.
  - If 1: go to OPEN and set `fail_cnt`=0.
  - If 0: pulse `lock_clr` and increment `fail_cnt`. If the new value equals `MAX_FAIL`, go to LOCKOUT; otherwise go to IDLE.
  - Clear `press_cnt` in both cases.
- **OPEN:** `door_open`=1 and presses are ignored. After `OPEN_CYC` cycles, pulse `lock_clr` and go to IDLE.
- **LOCKOUT:** `locked_out`=1 and presses are ignored (no pulses forwarded). After `LOCKOUT_CYC` cycles, set `fail_cnt`=0 and go to IDLE.
- **Saturation and unused encodings:** `fail_cnt` saturates at `MAX_FAIL`. Unused state encodings 5–7 go to IDLE on the next clock.

## Timing
- **Reset** (`rst`=0 at a rising edge):
  - `state`=IDLE;
  - `b0`=`b1`=`lock_clr`=`door_open`=`locked_out`=0;
  - `fail_cnt`=0; all counters 0;
  - previous-level registers loaded with the current `btn0`/`btn1`, so a button held through reset does not fire.
- **Reset mid-operation:** reset in any state aborts immediately. No `lock_clr` pulse is issued.
- **Registered outputs:** all outputs are registered.
- **Press latency:** for a press edge sampled at edge t, `b0`/`b1` is high during cycle t+1.
- **State update:** `state` changes at the same edge that accepts the `CODE_LEN`-th press. CHECK therefore begins together with the final pulse.
- **CHECK duration:** CHECK lasts `CHECK_WAIT`+1 cycles, covering the lock FSM's registered response.
- **`lock_clr`:** high for the single cycle after the deciding edge, coincident with the first cycle in the next state.
- **`door_open`:** high for exactly `OPEN_CYC` cycles.
- **`locked_out`:** high for exactly `LOCKOUT_CYC` cycles.
- **Timers:**
  - Width is $clog2 of the largest cycle parameter, plus 1.
  - Timers count 0..N-1 and reload on state entry.

## Test plan
- **Reset:**
  - Stimulus: hold `rst`=0 for 2 cycles, with `btn0`=1 held through release.
  - Required: all outputs 0, `state`=0, and no `b0` pulse after release.
- **Correct code:**
  - Stimulus: 4 presses, b0,b1,b0,b1; `unlock_in` driven 1 two cycles after the 4th pulse.
  - Required: 4 single-cycle pulses, `state` 0→1→2→3, `door_open` high for 16 cycles, then `lock_clr` pulse and `state`=0.
- **Three failures:**
  - Stimulus: three 4-press attempts with `unlock_in`=0.
  - Required:
    - `fail_cnt` 1, 2, 3, with a `lock_clr` pulse after each attempt.
    - `state`=4 and `locked_out` high for 32 cycles.
    - Presses during lockout produce no `b0`/`b1`.
    - After lockout: `fail_cnt`=0, `state`=0.
- **Simultaneous edge:**
  - Stimulus: `btn0` and `btn1` rise in the same cycle while in ENTRY.
  - Required: no pulse and `press_cnt` unchanged. A later single press still counts.
- **Inactivity timeout:**
  - Stimulus: 2 presses, then 20 idle cycles.
  - Required: `lock_clr` pulse, `state`=0, `fail_cnt` unchanged.
- **Reset mid-CHECK:**
  - Stimulus: assert `rst`=0 during CHECK with `fail_cnt`=2.
  - Required: `state`=0 and `fail_cnt`=0 next cycle, with no `lock_clr` pulse.

Source files
------------

// File: rtl/lock_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lock_ctrl_if
// Description : Keypad-side and lock-side signals of the attempt sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface lock_ctrl_if #(
    parameter int MAX_FAIL = 3
);
    logic                              btn0;
    logic                              btn1;
    logic                              unlock_in;
    logic                              b0;
    logic                              b1;
    logic                              lock_clr;
    logic                              door_open;
    logic                              locked_out;
    logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt;
    logic [2:0]                        state;

    modport master (
        output btn0, btn1, unlock_in,
        input  b0, b1, lock_clr, door_open, locked_out, fail_cnt, state
    );

    modport slave (
        input  btn0, btn1, unlock_in,
        output b0, b1, lock_clr, door_open, locked_out, fail_cnt, state
    );
endinterface
`default_nettype wire

// File: rtl/lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lock_ctrl
// Description : Press edge-detect, attempt grouping, failure count and lockout
//               sequencer in front of the two-button lock FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module lock_ctrl #(
    parameter int CODE_LEN    = 4,
    parameter int MAX_FAIL    = 3,
    parameter int CHECK_WAIT  = 2,
    parameter int OPEN_CYC    = 16,
    parameter int LOCKOUT_CYC = 32,
    parameter int IDLE_CYC    = 20
) (
    input  logic       clk,
    input  logic       rst,
    lock_ctrl_if.slave bus
);
    localparam int c_max_a = (CHECK_WAIT > OPEN_CYC) ? CHECK_WAIT : OPEN_CYC;
    localparam int c_max_b = (LOCKOUT_CYC > IDLE_CYC) ? LOCKOUT_CYC : IDLE_CYC;
    localparam int c_max_cyc = (c_max_a > c_max_b) ? c_max_a : c_max_b;
    localparam int TW = $clog2(c_max_cyc) + 1;
    localparam int PW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_entry   = 3'd1;
    localparam logic [2:0] c_st_check   = 3'd2;
    localparam logic [2:0] c_st_open    = 3'd3;
    localparam logic [2:0] c_st_lockout = 3'd4;

    localparam logic [TW-1:0] c_check_last = TW'(CHECK_WAIT);
    localparam logic [TW-1:0] c_open_last  = TW'(OPEN_CYC - 1);
    localparam logic [TW-1:0] c_lock_last  = TW'(LOCKOUT_CYC - 1);
    localparam logic [TW-1:0] c_idle_last  = TW'(IDLE_CYC - 1);
    localparam logic [PW-1:0] c_code_len   = PW'(CODE_LEN);
    localparam logic [FW-1:0] c_max_fail   = FW'(MAX_FAIL);

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic          r_prev0;
    logic          r_prev1;
    logic [TW-1:0] r_timer;
    logic [PW-1:0] r_press_cnt;
    logic [FW-1:0] r_fail;
    logic          r_b0;
    logic          r_b1;
    logic          r_clr;
    logic          r_door;
    logic          r_lockout;

    logic [TW-1:0] w_timer_d;
    logic [PW-1:0] w_press_d;
    logic [FW-1:0] w_fail_d;
    logic          w_clr_d;
    logic          w_b0_d;
    logic          w_b1_d;

    logic          w_rise0;
    logic          w_rise1;
    logic          w_accept;
    logic [PW-1:0] w_press_inc;
    logic          w_code_done;
    logic [FW-1:0] w_fail_inc;
    logic          w_fail_max;
    logic          w_idle_to;
    logic          w_check_done;
    logic          w_open_done;
    logic          w_lock_done;

    // A simultaneous rise on both buttons is ambiguous and is dropped.
    assign w_rise0      = bus.btn0 & ~r_prev0;
    assign w_rise1      = bus.btn1 & ~r_prev1;
    assign w_accept     = (w_rise0 ^ w_rise1) &&
                          ((r_state == c_st_idle) || (r_state == c_st_entry));
    assign w_press_inc  = r_press_cnt + PW'(1);
    assign w_code_done  = (w_press_inc == c_code_len);
    assign w_fail_inc   = (r_fail == c_max_fail) ? r_fail : r_fail + FW'(1);
    assign w_fail_max   = (w_fail_inc == c_max_fail);
    assign w_idle_to    = (r_timer == c_idle_last);
    assign w_check_done = (r_timer == c_check_last);
    assign w_open_done  = (r_timer == c_open_last);
    assign w_lock_done  = (r_timer == c_lock_last);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_next_state = w_code_done ? c_st_check : c_st_entry;
                end
            end
            c_st_entry: begin
                if (w_accept) begin
                    if (w_code_done) begin
                        w_next_state = c_st_check;
                    end
                end else if (w_idle_to) begin
                    w_next_state = c_st_idle;
                end
            end
            c_st_check: begin
                if (w_check_done) begin
                    if (bus.unlock_in) begin
                        w_next_state = c_st_open;
                    end else begin
                        w_next_state = w_fail_max ? c_st_lockout : c_st_idle;
                    end
                end
            end
            c_st_open: begin
                if (w_open_done) begin
                    w_next_state = c_st_idle;
                end
            end
            c_st_lockout: begin
                if (w_lock_done) begin
                    w_next_state = c_st_idle;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        w_timer_d = r_timer + TW'(1);
        w_press_d = r_press_cnt;
        w_fail_d  = r_fail;
        w_clr_d   = 1'b0;
        w_b0_d    = w_accept & w_rise0;
        w_b1_d    = w_accept & w_rise1;
        // Any accepted press or state change restarts the timer.
        if (w_accept || (w_next_state != r_state)) begin
            w_timer_d = '0;
        end
        if (w_accept) begin
            w_press_d = w_press_inc;
        end
        case (r_state)
            c_st_idle: begin
                w_timer_d = '0;
            end
            c_st_entry: begin
                if (!w_accept && w_idle_to) begin
                    w_clr_d   = 1'b1;
                    w_press_d = '0;
                end
            end
            c_st_check: begin
                if (w_check_done) begin
                    w_press_d = '0;
                    if (bus.unlock_in) begin
                        w_fail_d = '0;
                    end else begin
                        w_clr_d  = 1'b1;
                        w_fail_d = w_fail_inc;
                    end
                end
            end
            c_st_open: begin
                if (w_open_done) begin
                    w_clr_d = 1'b1;
                end
            end
            c_st_lockout: begin
                if (w_lock_done) begin
                    w_fail_d = '0;
                end
            end
            default: begin
                w_timer_d = '0;
                w_press_d = '0;
            end
        endcase
    end

    // Previous levels load from the live buttons in reset so a held key is silent.
    always_ff @(posedge clk) begin
        r_prev0 <= bus.btn0;
        r_prev1 <= bus.btn1;
        if (!rst) begin
            r_timer     <= '0;
            r_press_cnt <= '0;
            r_fail      <= '0;
            r_b0        <= 1'b0;
            r_b1        <= 1'b0;
            r_clr       <= 1'b0;
            r_door      <= 1'b0;
            r_lockout   <= 1'b0;
        end else begin
            r_timer     <= w_timer_d;
            r_press_cnt <= w_press_d;
            r_fail      <= w_fail_d;
            r_b0        <= w_b0_d;
            r_b1        <= w_b1_d;
            r_clr       <= w_clr_d;
            r_door      <= (w_next_state == c_st_open);
            r_lockout   <= (w_next_state == c_st_lockout);
        end
    end

    assign bus.b0         = r_b0;
    assign bus.b1         = r_b1;
    assign bus.lock_clr   = r_clr;
    assign bus.door_open  = r_door;
    assign bus.locked_out = r_lockout;
    assign bus.fail_cnt   = r_fail;
    assign bus.state      = r_state;
endmodule
`default_nettype wire

// File: tb/tb_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lock_ctrl
// Description : Scoreboard bench for lock_ctrl against a deadline-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lock_ctrl;
    localparam int CODE_LEN    = 4;
    localparam int MAX_FAIL    = 3;
    localparam int CHECK_WAIT  = 2;
    localparam int OPEN_CYC    = 16;
    localparam int LOCKOUT_CYC = 32;
    localparam int IDLE_CYC    = 20;
    localparam int FW          = $clog2(MAX_FAIL + 1);

    typedef struct packed {
        logic          b0;
        logic          b1;
        logic          clr;
        logic          door;
        logic          lo;
        logic [FW-1:0] fail;
        logic [2:0]    st;
    } exp_t;

    logic clk;
    logic rst;
    lock_ctrl_if #(.MAX_FAIL(MAX_FAIL)) bus ();

    lock_ctrl #(
        .CODE_LEN   (CODE_LEN),
        .MAX_FAIL   (MAX_FAIL),
        .CHECK_WAIT (CHECK_WAIT),
        .OPEN_CYC   (OPEN_CYC),
        .LOCKOUT_CYC(LOCKOUT_CYC),
        .IDLE_CYC   (IDLE_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference: states by number, timeouts as absolute edge deadlines.
    int m_cyc   = 0;
    int m_mode  = 0;
    int m_pres  = 0;
    int m_fail  = 0;
    int m_dl    = 0;
    bit m_prev0 = 1'b0;
    bit m_prev1 = 1'b0;
    bit cur_u   = 1'b0;

    task automatic model_step(input bit x0, input bit x1, input bit xu, input bit xr);
        exp_t e;
        bit   r0, r1, acc;
        e = '0;
        if (!xr) begin
            m_mode = 0;
            m_pres = 0;
            m_fail = 0;
        end else begin
            r0  = x0 && !m_prev0;
            r1  = x1 && !m_prev1;
            acc = (r0 != r1) && (m_mode == 0 || m_mode == 1);
            if (acc) begin
                e.b0 = r0;
                e.b1 = r1;
                m_pres++;
                if (m_pres == CODE_LEN) begin
                    m_mode = 2;
                    m_dl   = m_cyc + CHECK_WAIT + 1;
                end else begin
                    m_mode = 1;
                    m_dl   = m_cyc + IDLE_CYC;
                end
            end else if (m_mode == 1 && m_cyc == m_dl) begin
                e.clr  = 1'b1;
                m_mode = 0;
                m_pres = 0;
            end else if (m_mode == 2 && m_cyc == m_dl) begin
                m_pres = 0;
                if (xu) begin
                    m_mode = 3;
                    m_fail = 0;
                    m_dl   = m_cyc + OPEN_CYC;
                end else begin
                    e.clr = 1'b1;
                    if (m_fail < MAX_FAIL) m_fail++;
                    if (m_fail == MAX_FAIL) begin
                        m_mode = 4;
                        m_dl   = m_cyc + LOCKOUT_CYC;
                    end else begin
                        m_mode = 0;
                    end
                end
            end else if (m_mode == 3 && m_cyc == m_dl) begin
                e.clr  = 1'b1;
                m_mode = 0;
            end else if (m_mode == 4 && m_cyc == m_dl) begin
                m_fail = 0;
                m_mode = 0;
            end
        end
        m_prev0 = x0;
        m_prev1 = x1;
        e.door  = (m_mode == 3);
        e.lo    = (m_mode == 4);
        e.fail  = FW'(m_fail);
        e.st    = 3'(m_mode);
        q.push_back(e);
        m_cyc++;
    endtask

    task automatic tick(input bit x0, input bit x1, input bit xr);
        bus.btn0      = x0;
        bus.btn1      = x1;
        bus.unlock_in = cur_u;
        rst           = xr;
        model_step(x0, x1, cur_u, xr);
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int which);
        tick(which == 0, which == 1, 1'b1);
        repeat ($urandom_range(1, 3)) tick(1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 1'b1);
    endtask

    task automatic attempt();
        for (int k = 0; k < CODE_LEN; k++) press(int'($urandom_range(0, 1)));
    endtask

    initial begin : monitor
        exp_t got;
        exp_t exp;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp = q.pop_front();
                got = '{bus.b0, bus.b1, bus.lock_clr, bus.door_open,
                        bus.locked_out, bus.fail_cnt, bus.state};
                n_vec++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL cycle %0d outputs: got st=%0d b0=%b b1=%b clr=%b door=%b lo=%b fail=%0d, expected st=%0d b0=%b b1=%b clr=%b door=%b lo=%b fail=%0d",
                             n_vec, got.st, got.b0, got.b1, got.clr, got.door, got.lo, got.fail,
                             exp.st, exp.b0, exp.b1, exp.clr, exp.door, exp.lo, exp.fail);
                end
            end
        end
    end

    initial begin : driver
        // Reset with btn0 held through release.
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        idle(2);

        // Correct code.
        cur_u = 1'b1;
        press(0); press(1); press(0); press(1);
        idle(OPEN_CYC + 6);

        // Three failures, presses during lockout.
        cur_u = 1'b0;
        for (int a = 0; a < MAX_FAIL; a++) begin
            attempt();
            idle(CHECK_WAIT + 3);
        end
        for (int k = 0; k < 8; k++) press(int'($urandom_range(0, 1)));
        idle(LOCKOUT_CYC);

        // Simultaneous rise in ENTRY, then a normal press still counts.
        cur_u = 1'b1;
        press(0);
        tick(1'b1, 1'b1, 1'b1);
        idle(2);
        press(1); press(0); press(1);
        idle(OPEN_CYC + 6);

        // Inactivity timeout after two presses.
        cur_u = 1'b0;
        attempt();
        idle(CHECK_WAIT + 3);
        press(0); press(1);
        idle(IDLE_CYC + 3);

        // Reset during CHECK with two failures recorded.
        attempt();
        idle(CHECK_WAIT + 3);
        press(1); press(0); press(1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        idle(4);

        // Random traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            bit x0, x1, xr;
            cur_u = ($urandom_range(0, 9) < 4);
            x0 = ($urandom_range(0, 9) < 3);
            x1 = ($urandom_range(0, 9) < 3);
            xr = ($urandom_range(0, 299) != 0);
            tick(x0, x1, xr);
        end
        idle(3);

        repeat (4) @(negedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected vectors left unchecked, 0 required", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
